tennis_score_fsm: RTL and testbench

Scoring engine for one tennis game, sitting directly upstream of the score-display stage. It converts two player point buttons into registered per-player score codes (`p0`, `p1`) and a game-over flag (`squash`). Deuce and advantage follow standard tennis rules. After a win it freezes and presents the winner until a new game is requested.

---
 rtl/tennis_pkg.sv | 28 ++
 rtl/point_pulse.sv | 72 +++++++
 rtl/tennis_score_fsm.sv | 183 ++++++++++++++++++
 tb/tb_tennis_score_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis game scoring engine.
package tennis_pkg;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    DEUCE = 3'd1,
    ADV0  = 3'd2,
    ADV1  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] LOVE    = 2'd0;
  localparam logic [1:0] FIFTEEN = 2'd1;
  localparam logic [1:0] THIRTY  = 2'd2;
  localparam logic [1:0] FORTY   = 2'd3;

  localparam logic [1:0] WIN_P0 = 2'd1;
  localparam logic [1:0] WIN_P1 = 2'd2;

  function automatic logic [1:0] adv_code(input state_t s);
    case (s)
      ADV0:    return 2'b01;
      ADV1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/point_pulse.sv
// Button conditioning: 2-flop synchronizer, optional debounce (TENNIS_DEBOUNCE_EN),
// rising-edge detector and registered one-cycle point pulse.
module point_pulse #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic prev_r;
  logic pulse_r;

  // two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync2_next(sync1_r);
    end
  end

  function automatic logic sync2_next(input logic d);
    return d;
  endfunction

`ifdef TENNIS_DEBOUNCE_EN
  logic [15:0] cnt_r;
  logic        stable_r;

  // accept a new level only after DEBOUNCE_CYCLES identical samples; any bounce restarts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 16'd0;
      stable_r <= 1'b0;
    end else if (sync2_r != stable_r) begin
      if (cnt_r == DEBOUNCE_CYCLES - 16'd1) begin
        stable_r <= sync2_r;
        cnt_r    <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end else begin
      cnt_r <= 16'd0;
    end
  end

  assign level_s = stable_r;
`else
  assign level_s = sync2_r;
`endif

  // rising-edge detect; a held button produces a single pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      prev_r  <= level_s;
      pulse_r <= level_s & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/tennis_score_fsm.sv
// One-game tennis scoring FSM with registered score, advantage and game-over outputs.
// Optional button debounce is enabled with the TENNIS_DEBOUNCE_EN macro.
module tennis_score_fsm
  import tennis_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       new_game,
  output logic [1:0] p0,
  output logic [1:0] p1,
  output logic       squash,
  output logic [1:0] adv,
  output logic       point_seen
);

  logic       pt0_s;
  logic       pt1_s;
  logic       accept0_s;
  logic       accept1_s;

  state_t     state_r;
  state_t     state_s;
  logic [1:0] s0_r;
  logic [1:0] s0_s;
  logic [1:0] s1_r;
  logic [1:0] s1_s;
  logic [1:0] win_r;
  logic [1:0] win_s;
  logic       seen_s;

  logic [1:0] p0_r;
  logic [1:0] p1_r;
  logic [1:0] adv_r;
  logic       squash_r;
  logic       seen_r;

  point_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pulse0 (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn0),
    .pulse (pt0_s)
  );

  point_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pulse1 (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn1),
    .pulse (pt1_s)
  );

  // simultaneous pulses cancel each other
  assign accept0_s = pt0_s & ~pt1_s;
  assign accept1_s = pt1_s & ~pt0_s;

  // next-state and score logic; new_game overrides any pulse on the same edge
  always_comb begin
    state_s = state_r;
    s0_s    = s0_r;
    s1_s    = s1_r;
    win_s   = win_r;
    seen_s  = 1'b0;
    if (new_game) begin
      state_s = PLAY;
      s0_s    = LOVE;
      s1_s    = LOVE;
      win_s   = 2'd0;
    end else begin
      case (state_r)
        PLAY: begin
          if (accept0_s) begin
            seen_s = 1'b1;
            if (s0_r != FORTY) begin
              s0_s = s0_r + 2'd1;
              if (s0_r == THIRTY && s1_r == FORTY) begin
                state_s = DEUCE;
              end else begin
                state_s = PLAY;
              end
            end else begin
              state_s = OVER;
              win_s   = WIN_P0;
            end
          end else if (accept1_s) begin
            seen_s = 1'b1;
            if (s1_r != FORTY) begin
              s1_s = s1_r + 2'd1;
              if (s1_r == THIRTY && s0_r == FORTY) begin
                state_s = DEUCE;
              end else begin
                state_s = PLAY;
              end
            end else begin
              state_s = OVER;
              win_s   = WIN_P1;
            end
          end else begin
            state_s = PLAY;
          end
        end
        DEUCE: begin
          if (accept0_s) begin
            seen_s  = 1'b1;
            state_s = ADV0;
          end else if (accept1_s) begin
            seen_s  = 1'b1;
            state_s = ADV1;
          end else begin
            state_s = DEUCE;
          end
        end
        ADV0: begin
          if (accept0_s) begin
            seen_s  = 1'b1;
            state_s = OVER;
            win_s   = WIN_P0;
          end else if (accept1_s) begin
            seen_s  = 1'b1;
            state_s = DEUCE;
          end else begin
            state_s = ADV0;
          end
        end
        ADV1: begin
          if (accept1_s) begin
            seen_s  = 1'b1;
            state_s = OVER;
            win_s   = WIN_P1;
          end else if (accept0_s) begin
            seen_s  = 1'b1;
            state_s = DEUCE;
          end else begin
            state_s = ADV1;
          end
        end
        OVER: begin
          state_s = OVER;
        end
        default: begin
          state_s = PLAY;
          s0_s    = LOVE;
          s1_s    = LOVE;
          win_s   = 2'd0;
        end
      endcase
    end
  end

  // state, score and output registers; outputs are derived from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= PLAY;
      s0_r     <= LOVE;
      s1_r     <= LOVE;
      win_r    <= 2'd0;
      p0_r     <= LOVE;
      p1_r     <= LOVE;
      adv_r    <= 2'b00;
      squash_r <= 1'b0;
      seen_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      s0_r     <= s0_s;
      s1_r     <= s1_s;
      win_r    <= win_s;
      p0_r     <= (state_s == OVER) ? win_s : s0_s;
      p1_r     <= (state_s == OVER) ? LOVE : s1_s;
      adv_r    <= adv_code(state_s);
      squash_r <= (state_s == OVER);
      seen_r   <= seen_s;
    end
  end

  assign p0         = p0_r;
  assign p1         = p1_r;
  assign adv        = adv_r;
  assign squash     = squash_r;
  assign point_seen = seen_r;

endmodule

// File: tb/tb_tennis_score_fsm.sv
// Scoreboard bench for tennis_score_fsm: point-count reference model, randomized rallies.
module tb_tennis_score_fsm;

`ifdef TENNIS_DEBOUNCE_EN
  localparam int LAT  = 12;
  localparam int HOLD = 12;
  localparam int GAP  = 14;
`else
  localparam int LAT  = 4;
  localparam int HOLD = 2;
  localparam int GAP  = 4;
`endif

  logic       clk;
  logic       rst;
  logic       btn0;
  logic       btn1;
  logic       new_game;
  logic [1:0] p0;
  logic [1:0] p1;
  logic       squash;
  logic [1:0] adv;
  logic       point_seen;

  tennis_score_fsm #(.DEBOUNCE_CYCLES(16'd8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn0       (btn0),
    .btn1       (btn1),
    .new_game   (new_game),
    .p0         (p0),
    .p1         (p1),
    .squash     (squash),
    .adv        (adv),
    .point_seen (point_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_point;
    int         cyc;
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] adv;
    logic       sq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic chk_req = 1'b0;

  // reference model: raw points won by each player
  int a;
  int b;
  bit over_m;
  int winner_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    a = 0; b = 0; over_m = 1'b0; winner_m = 0;
  endfunction

  function automatic bit score_point(int who);
    if (over_m) return 1'b0;
    if (who == 0) a++; else b++;
    if ((a >= 4 || b >= 4) && (a - b >= 2 || b - a >= 2)) begin
      over_m   = 1'b1;
      winner_m = (a > b) ? 0 : 1;
    end
    return 1'b1;
  endfunction

  function automatic exp_t snap(bit is_pt, int c);
    exp_t e;
    e.is_point = is_pt;
    e.cyc      = c;
    if (over_m) begin
      e.p0 = (winner_m == 0) ? 2'd1 : 2'd2;
      e.p1 = 2'd0; e.sq = 1'b1; e.adv = 2'b00;
    end else if (a >= 3 && b >= 3) begin
      e.p0 = 2'd3; e.p1 = 2'd3; e.sq = 1'b0;
      e.adv = (a > b) ? 2'b01 : ((b > a) ? 2'b10 : 2'b00);
    end else begin
      e.p0 = (a > 3) ? 2'd3 : a[1:0];
      e.p1 = (b > 3) ? 2'd3 : b[1:0];
      e.sq = 1'b0; e.adv = 2'b00;
    end
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(int who, int hold);
    if (score_point(who)) q.push_back(snap(1'b1, cyc + LAT));
    if (who == 0) btn0 = 1'b1; else btn1 = 1'b1;
    tick(hold);
    btn0 = 1'b0; btn1 = 1'b0;
    tick(GAP);
  endtask

  task automatic both();
    btn0 = 1'b1; btn1 = 1'b1;
    tick(HOLD);
    btn0 = 1'b0; btn1 = 1'b0;
    tick(GAP);
  endtask

  task automatic idle_check();
    q.push_back(snap(1'b0, 0));
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    model_reset();
    idle_check();
  endtask

  // monitor: pops on every point strobe and on every quiet-state check request
  always @(negedge clk) begin : mon
    exp_t e;
    if (point_seen === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL point_seen: unexpected strobe at cycle %0d (p0=%0d p1=%0d sq=%0d adv=%b)", cyc, p0, p1, squash, adv);
      end else begin
        e = q.pop_front();
        if (!e.is_point || e.cyc != cyc || p0 !== e.p0 || p1 !== e.p1 || squash !== e.sq || adv !== e.adv) begin
          errors++;
          $display("FAIL point: got cyc=%0d p0=%0d p1=%0d sq=%0d adv=%b, exp point=%0d cyc=%0d p0=%0d p1=%0d sq=%0d adv=%b",
                   cyc, p0, p1, squash, adv, e.is_point, e.cyc, e.p0, e.p1, e.sq, e.adv);
        end
      end
    end
    if (chk_req) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL idle: scoreboard empty at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        if (e.is_point || point_seen !== 1'b0 || p0 !== e.p0 || p1 !== e.p1 || squash !== e.sq || adv !== e.adv) begin
          errors++;
          $display("FAIL idle: got seen=%0d p0=%0d p1=%0d sq=%0d adv=%b, exp point=%0d p0=%0d p1=%0d sq=%0d adv=%b",
                   point_seen, p0, p1, squash, adv, e.is_point, e.p0, e.p1, e.sq, e.adv);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst = 1'b1; btn0 = 1'b0; btn1 = 1'b0; new_game = 1'b0;
    model_reset();
    tick(3);
    idle_check();
    rst = 1'b0;
    tick(2);
    idle_check();

    // straight win for player 0, then presses ignored in OVER
    repeat (4) press(0, HOLD);
    idle_check();
    press(1, HOLD);
    press(0, HOLD);
    idle_check();
    do_new_game();

    // deuce, advantage, back to deuce, win
    repeat (3) press(0, HOLD);
    repeat (3) press(1, HOLD);
    idle_check();
    press(1, HOLD);
    idle_check();
    press(0, HOLD);
    idle_check();
    press(0, HOLD);
    press(0, HOLD);
    idle_check();
    do_new_game();

    // simultaneous presses at 1/1 are discarded
    press(0, HOLD);
    press(1, HOLD);
    both();
    idle_check();

    // long hold counts once
    press(0, 100);
    idle_check();

    // reset with a pulse in flight
    btn0 = 1'b1;
    tick(1);
    btn0 = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(GAP);
    idle_check();

`ifdef TENNIS_DEBOUNCE_EN
    // short glitch is filtered out
    btn0 = 1'b1;
    tick(5);
    btn0 = 1'b0;
    tick(GAP);
    idle_check();
`endif

    do_new_game();
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) do_new_game();
      else if (r == 1) both();
      else if (r == 2) idle_check();
      else if (r < 11) press(0, HOLD);
      else press(1, HOLD);
    end
    idle_check();

    tick(2 * GAP);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never seen, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
